arrhythmia_feature_capture: RTL and testbench

//  Upstream stage of the arrhythmia decision-tree classifier. Accepts one patient record as a byte

---
 rtl/arrhythmia_feature_capture.sv | 149 ++++++++++++++
 tb/tb_arrhythmia_feature_capture.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arrhythmia_feature_capture.sv
// ----------------------------------------------------------------------------
// arrhythmia_feature_capture
//  Front stage of the arrhythmia decision-tree classifier. It takes one patient
//  record as a byte stream of N_FEATURES features over a valid/ready handshake
//  and keeps only the five features the tree uses. Those five are presented as
//  a held vector with an out_valid/out_ready handshake. A record whose length
//  does not match N_FEATURES raises a one-cycle err_len pulse and is discarded.
//
//  Ports
//   clk, rst              clock (rising edge), synchronous active-high reset
//   in_valid/in_ready     input byte handshake
//   in_data, in_last      feature value, final-byte marker
//   out_valid/out_ready   captured-vector handshake
//   X13..X278             captured features, held while out_valid=1
//   err_len               one-cycle pulse on a record-length error
//   vec_count             number of emitted vectors, saturating
// ----------------------------------------------------------------------------
module arrhythmia_feature_capture #(
   parameter int unsigned N_FEATURES = 279,
   parameter int unsigned W          = 8,
   parameter int unsigned IDX_W      = 9,
   parameter int unsigned IDX_A      = 13,
   parameter int unsigned IDX_B      = 27,
   parameter int unsigned IDX_C      = 235,
   parameter int unsigned IDX_D      = 264,
   parameter int unsigned IDX_E      = 278
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_data,
   input  logic          in_last,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  X13,
   output logic [W-1:0]  X27,
   output logic [W-1:0]  X235,
   output logic [W-1:0]  X264,
   output logic [W-1:0]  X278,
   output logic          err_len,
   output logic [15:0]   vec_count
);

   localparam int unsigned CNT_W = 16;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_FEATURES - 1);

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      HOLD    = 2'd1,
      DROP    = 2'd2
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [IDX_W-1:0]   idx;
   logic [IDX_W-1:0]   idx_next;
   logic               err_next;
   logic               cap_en;
   logic               cnt_inc;
   logic               accept;

   assign accept = in_valid && in_ready;

   // State, index, captured features, error pulse and emitted-vector counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= COLLECT;
         idx       <= '0;
         X13       <= '0;
         X27       <= '0;
         X235      <= '0;
         X264      <= '0;
         X278      <= '0;
         err_len   <= 1'b0;
         vec_count <= '0;
      end else begin
         state   <= state_next;
         idx     <= idx_next;
         err_len <= err_next;
         if (cap_en) begin
            if (idx == IDX_W'(IDX_A)) X13  <= in_data;
            if (idx == IDX_W'(IDX_B)) X27  <= in_data;
            if (idx == IDX_W'(IDX_C)) X235 <= in_data;
            if (idx == IDX_W'(IDX_D)) X264 <= in_data;
            if (idx == IDX_W'(IDX_E)) X278 <= in_data;
         end
         if (cnt_inc && (vec_count != {CNT_W{1'b1}}))
            vec_count <= vec_count + CNT_W'(1);
      end
   end

   // Next-state, index and error decisions
   always_comb begin
      state_next = state;
      idx_next   = idx;
      err_next   = 1'b0;
      cap_en     = 1'b0;
      cnt_inc    = 1'b0;
      case (state)
         COLLECT: begin
            if (accept) begin
               cap_en = 1'b1;
               if (idx != IDX_LAST) begin
                  if (in_last) begin
                     // record ended early: flag it and restart at index 0
                     err_next = 1'b1;
                     idx_next = '0;
                  end else begin
                     idx_next = idx + IDX_W'(1);
                  end
               end else begin
                  idx_next = '0;
                  if (in_last) begin
                     state_next = HOLD;
                  end else begin
                     // record too long: flush the remainder up to in_last
                     err_next   = 1'b1;
                     state_next = DROP;
                  end
               end
            end
         end
         HOLD: begin
            if (out_ready) begin
               cnt_inc    = 1'b1;
               state_next = COLLECT;
            end
         end
         DROP: begin
            if (accept && in_last) begin
               state_next = COLLECT;
               idx_next   = '0;
            end
         end
         default: begin
            state_next = COLLECT;
            idx_next   = '0;
         end
      endcase
   end

   // Handshake outputs decoded from the state register
   always_comb begin
      in_ready  = (state != HOLD);
      out_valid = (state == HOLD);
   end

endmodule

// File: tb/tb_arrhythmia_feature_capture.sv
// ----------------------------------------------------------------------------
// tb_arrhythmia_feature_capture
//  Directed self-checking bench for arrhythmia_feature_capture. Inputs change
//  1 time unit after the rising edge; outputs are sampled at the same point.
// ----------------------------------------------------------------------------
module tb_arrhythmia_feature_capture;

   localparam int unsigned W = 8;
   localparam int unsigned N = 279;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic          in_last;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  X13, X27, X235, X264, X278;
   logic          err_len;
   logic [15:0]   vec_count;

   int n_tests;
   int n_fail;

   // Expected vector for a record whose byte k equals k[7:0]
   logic [5*W-1:0] exp_vec;
   logic [5*W-1:0] zero_vec;

   arrhythmia_feature_capture dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .X13       (X13),
      .X27       (X27),
      .X235      (X235),
      .X264      (X264),
      .X278      (X278),
      .err_len   (err_len),
      .vec_count (vec_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Present one byte and wait (bounded) until it is accepted
   task automatic send(input logic [W-1:0] d, input logic l, input logic gaps);
      int n;
      if (gaps && ($urandom_range(0, 1) == 1)) begin
         in_valid = 1'b0;
         tick();
      end
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      n = 0;
      while (!in_ready && n < 100) begin
         tick();
         n++;
      end
      if (n >= 100) begin
         n_tests++;
         n_fail++;
         $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Bytes k = first..last_k with value k[7:0]; in_last only if mark_last
   task automatic send_range(input int first, input int last_k, input logic mark_last,
                             input logic gaps);
      for (int k = first; k <= last_k; k++)
         send(8'(k), mark_last && (k == last_k), gaps);
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      n_tests++;
      if ({X13, X27, X235, X264, X278} !== zero_vec) begin
         n_fail++;
         $display("FAIL reset_x: got %h required %h", {X13, X27, X235, X264, X278}, zero_vec);
      end
      n_tests++;
      if ({out_valid, err_len, in_ready, vec_count} !== {1'b0, 1'b0, 1'b1, 16'd0}) begin
         n_fail++;
         $display("FAIL reset_ctl: out_valid=%0b err_len=%0b in_ready=%0b vec_count=%0d required 0/0/1/0",
                  out_valid, err_len, in_ready, vec_count);
      end
   endtask

   task automatic test_single_record();
      apply_reset();
      send_range(0, N - 2, 1'b0, 1'b0);
      n_tests++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rec_early_valid: out_valid=%0b required 0", out_valid);
      end
      send(8'(N - 1), 1'b1, 1'b0);
      n_tests++;
      if ({out_valid, in_ready, err_len} !== 3'b100) begin
         n_fail++;
         $display("FAIL rec_valid_rise: out_valid/in_ready/err_len=%b required 100",
                  {out_valid, in_ready, err_len});
      end
      n_tests++;
      if ({X13, X27, X235, X264, X278} !== exp_vec) begin
         n_fail++;
         $display("FAIL rec_vector: got %h required %h", {X13, X27, X235, X264, X278}, exp_vec);
      end
      handshake();
      n_tests++;
      if ({out_valid, in_ready, vec_count} !== {1'b0, 1'b1, 16'd1}) begin
         n_fail++;
         $display("FAIL rec_handshake: out_valid=%0b in_ready=%0b vec_count=%0d required 0/1/1",
                  out_valid, in_ready, vec_count);
      end
   endtask

   task automatic test_backpressure();
      int bad;
      apply_reset();
      send_range(0, N - 1, 1'b1, 1'b0);
      // offer a byte that must not be consumed while the vector is held
      in_valid = 1'b1;
      in_data  = 8'hAA;
      in_last  = 1'b1;
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if ({out_valid, in_ready, err_len} !== 3'b100 ||
             {X13, X27, X235, X264, X278} !== exp_vec)
            bad++;
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL hold_stable: %0d bad cycles required 0", bad);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      handshake();
      n_tests++;
      if ({out_valid, vec_count} !== {1'b0, 16'd1}) begin
         n_fail++;
         $display("FAIL hold_release: out_valid=%0b vec_count=%0d required 0/1", out_valid, vec_count);
      end
      // a consumed hold byte would misalign this record
      send_range(0, N - 1, 1'b1, 1'b0);
      n_tests++;
      if ({out_valid, err_len, X13, X27, X235, X264, X278} !== {2'b10, exp_vec}) begin
         n_fail++;
         $display("FAIL hold_next_rec: got %h required %h",
                  {out_valid, err_len, X13, X27, X235, X264, X278}, {2'b10, exp_vec});
      end
      handshake();
   endtask

   task automatic test_early_last();
      apply_reset();
      send_range(0, 100, 1'b1, 1'b0);
      n_tests++;
      if ({err_len, out_valid} !== 2'b10) begin
         n_fail++;
         $display("FAIL early_err: err_len/out_valid=%b required 10", {err_len, out_valid});
      end
      tick();
      n_tests++;
      if ({err_len, out_valid} !== 2'b00) begin
         n_fail++;
         $display("FAIL early_pulse: err_len/out_valid=%b required 00", {err_len, out_valid});
      end
      send_range(0, N - 1, 1'b1, 1'b0);
      n_tests++;
      if ({out_valid, err_len, X13, X27, X235, X264, X278} !== {2'b10, exp_vec}) begin
         n_fail++;
         $display("FAIL early_next_rec: got %h required %h",
                  {out_valid, err_len, X13, X27, X235, X264, X278}, {2'b10, exp_vec});
      end
      handshake();
      n_tests++;
      if (vec_count !== 16'd1) begin
         n_fail++;
         $display("FAIL early_count: vec_count=%0d required 1", vec_count);
      end
   endtask

   task automatic test_missing_last();
      int errs;
      apply_reset();
      send_range(0, N - 1, 1'b0, 1'b0);
      n_tests++;
      if ({err_len, out_valid, in_ready} !== 3'b101) begin
         n_fail++;
         $display("FAIL miss_err: err_len/out_valid/in_ready=%b required 101",
                  {err_len, out_valid, in_ready});
      end
      // dropped bytes carry values that must not reach the X registers
      errs = 0;
      for (int i = 0; i < 5; i++) begin
         send(8'hF0 + 8'(i), (i == 4), 1'b0);
         if (err_len !== 1'b0 || out_valid !== 1'b0) errs++;
      end
      n_tests++;
      if (errs != 0) begin
         n_fail++;
         $display("FAIL miss_drop_ctl: %0d bad cycles required 0", errs);
      end
      n_tests++;
      if ({X13, X27, X235, X264, X278} !== exp_vec) begin
         n_fail++;
         $display("FAIL miss_drop_x: got %h required %h", {X13, X27, X235, X264, X278}, exp_vec);
      end
      send_range(0, N - 1, 1'b1, 1'b0);
      n_tests++;
      if ({out_valid, err_len, X13, X27, X235, X264, X278} !== {2'b10, exp_vec}) begin
         n_fail++;
         $display("FAIL miss_next_rec: got %h required %h",
                  {out_valid, err_len, X13, X27, X235, X264, X278}, {2'b10, exp_vec});
      end
      handshake();
      n_tests++;
      if (vec_count !== 16'd1) begin
         n_fail++;
         $display("FAIL miss_count: vec_count=%0d required 1", vec_count);
      end
   endtask

   task automatic test_mid_reset();
      apply_reset();
      send_range(0, N - 1, 1'b1, 1'b0);
      handshake();
      send_range(0, 149, 1'b0, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_tests++;
      if ({out_valid, vec_count, X13, X27, X235, X264, X278} !== {1'b0, 16'd0, zero_vec}) begin
         n_fail++;
         $display("FAIL rst_mid: got %h required %h",
                  {out_valid, vec_count, X13, X27, X235, X264, X278}, {1'b0, 16'd0, zero_vec});
      end
      send_range(0, N - 1, 1'b1, 1'b0);
      n_tests++;
      if ({out_valid, err_len, X13, X27, X235, X264, X278} !== {2'b10, exp_vec}) begin
         n_fail++;
         $display("FAIL rst_next_rec: got %h required %h",
                  {out_valid, err_len, X13, X27, X235, X264, X278}, {2'b10, exp_vec});
      end
      handshake();
      n_tests++;
      if (vec_count !== 16'd1) begin
         n_fail++;
         $display("FAIL rst_count: vec_count=%0d required 1", vec_count);
      end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      for (int r = 0; r < 3; r++) begin
         send_range(0, N - 1, 1'b1, 1'b1);
         n_tests++;
         if ({out_valid, err_len, X13, X27, X235, X264, X278} !== {2'b10, exp_vec}) begin
            n_fail++;
            $display("FAIL gaps_rec%0d: got %h required %h", r,
                     {out_valid, err_len, X13, X27, X235, X264, X278}, {2'b10, exp_vec});
         end
         handshake();
      end
      n_tests++;
      if (vec_count !== 16'd3) begin
         n_fail++;
         $display("FAIL gaps_count: vec_count=%0d required 3", vec_count);
      end
   endtask

   initial begin
      n_tests  = 0;
      n_fail   = 0;
      exp_vec  = {8'd13, 8'd27, 8'd235, 8'd8, 8'd22};
      zero_vec = '0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      test_reset();
      test_single_record();
      test_backpressure();
      test_early_last();
      test_missing_last();
      test_mid_reset();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
